hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 8-bit, 8-register five-stage core. It drives the pipeline-register enables, bubble and flush controls that sit around the EX-stage forwarding unit and ALU input muxes. It handles four cases:
- load-use stalls, which forwarding cannot cover;
- multi-cycle multiply occupancy of EX;
- taken-branch squash;
- global data-memory freeze.

It also keeps saturating performance counters and a sticky protocol-error flag.

## Interface
Parameters:
- MUL_LAT, 4: cycles a multiply occupies EX; legal range 2..15.
- CNT_W, 16: width of the performance counters.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- mem_stall  in  1  data memory not ready; freezes the whole pipeline.
- branch_taken  in  1  branch resolved taken in EX; held stable by its source while mem_stall=1.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_rs, id_rt  in  3 each  source registers of the ID instruction.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction actually reads rs / rt.
- id_is_mul  in  1  the ID instruction is a multiply.
- ex_valid, ex_memread, ex_regwrite  in  1 each  status of the EX instruction.
- ex_rd  in  3  destination register of the EX instruction.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to NOP on the next edge.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_bubble  out  1  load zeroed control into ID/EX. Meaningful only when id_ex_write=1.
- mul_busy  out  1  state == MUL_BUSY.
- stall_count  out  CNT_W  cycles in which the front end was held.
- flush_count  out  CNT_W  taken branches accepted.
- proto_err  out  1  sticky flag: branch_taken seen in MUL_BUSY.

## Operation
- States: RUN (0) and MUL_BUSY (1). There is one registered down-counter, mcnt (4 bits).
- Load-use hazard (lu) is asserted when all of these hold: id_valid, ex_valid, ex_memread, ex_regwrite, ex_rd≠0, and ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)). r0 never causes a hazard.
- Outputs are combinational from state and inputs. The highest-priority condition that holds wins:
  1. rst_n=0: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_write=1, id_ex_bubble=1.
  2. mem_stall=1: all enables 0, flush/bubble 0. State, mcnt and counters hold.
  3. MUL_BUSY: pc_write, if_id_write and id_ex_write are 0. branch_taken is ignored and sets proto_err. stall_count increments.
  4. RUN with branch_taken: pc_write=1, if_id_flush=1, id_ex_write=1, id_ex_bubble=1. flush_count increments. Any lu or mul issue in the same cycle is discarded.
  5. RUN with lu: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1. stall_count increments.
  6. RUN otherwise: all enables 1, flush/bubble 0.
- Multiply issue occurs in RUN when id_valid & id_is_mul & no branch_taken & no lu & no mem_stall. Next state is MUL_BUSY, with mcnt=MUL_LAT-1.
- In MUL_BUSY (not stalled), mcnt decrements each cycle. When mcnt==1, the next state is RUN.
- Counters saturate at all-ones and never wrap.
- Synchronous reset sets: state RUN, mcnt 0, counters 0, proto_err 0. This includes reset asserted mid-MUL_BUSY.

## Timing
- Load-use costs exactly 1 stall cycle. In the following cycle the load is in MEM, lu is false, and the EX/MEM forwarding path supplies the data.
- Multiply issued in cycle t:
  - It occupies EX during cycles t+1 … t+MUL_LAT.
  - The front end is frozen during t+1 … t+MUL_LAT-1 (MUL_LAT-1 cycles added to stall_count).
  - The state is RUN at cycle t+MUL_LAT, so ID/EX loads the next instruction at the end of t+MUL_LAT.
- mem_stall stretches every sequence cycle-for-cycle; no event is lost or duplicated.
- A taken branch squashes 2 instructions (IF/ID and ID/EX) with zero added latency beyond those 2 cycles.
- Counter updates and proto_err are registered: visible one cycle after the qualifying cycle.

## Test plan
- Load-use: ex_memread=1, ex_regwrite=1, ex_rd=3, id_rs=3, id_uses_rs=1 → pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle; stall_count=1. Repeating the stimulus with ex_rd=0 → no stall.
- Multiply with MUL_LAT=4, id_is_mul=1 at cycle t → mul_busy=1 and id_ex_write=0 during t+1..t+3; mul_busy=0 at t+4; stall_count=3.
- Branch with lu in the same cycle: branch_taken=1 together with a load-use match → if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1; stall_count unchanged.
- Global freeze: mem_stall=1 for 3 cycles in the middle of MUL_BUSY with mcnt=2 → all enables 0, mcnt still 2 afterward; total mul_busy high time = MUL_LAT-1+3 cycles.
- Protocol error and reset: branch_taken=1 during MUL_BUSY → proto_err=1 and no flush. Then rst_n=0 for one edge → state RUN, proto_err=0, counters 0; while rst_n=0, if_id_flush=1 and id_ex_bubble=1.
- Saturation: force 2^CNT_W+5 load-use stalls → stall_count=all-ones, with no wrap.

Source files
------------

// File: rtl/hazard_controller.sv
// ----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline sequencing controller for the 8-bit, 8-register five-stage core.
// Generates the pipeline-register enables, ID/EX bubble and IF/ID flush that
// resolve load-use hazards, multi-cycle multiply occupancy of EX, taken-branch
// squash and the global data-memory freeze. It also keeps saturating
// performance counters and a sticky protocol-error flag.
//
// Parameters:
//   MUL_LAT  cycles a multiply occupies EX (2..15)
//   CNT_W    performance counter width
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   mem_stall                    data memory not ready, freezes everything
//   branch_taken                 branch resolved taken in EX
//   id_valid, id_rs, id_rt,
//   id_uses_rs, id_uses_rt,
//   id_is_mul                    ID-stage instruction status
//   ex_valid, ex_memread,
//   ex_regwrite, ex_rd           EX-stage instruction status
//   pc_write, if_id_write        front-end load enables
//   if_id_flush                  clear IF/ID to NOP
//   id_ex_write, id_ex_bubble    ID/EX load enable / load zeroed control
//   mul_busy                     multiply occupying EX
//   stall_count, flush_count     saturating performance counters
//   proto_err                    sticky: branch_taken seen while busy
// ----------------------------------------------------------------------------
module hazard_controller #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_stall,
    input  logic             branch_taken,
    input  logic             id_valid,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_mul,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [2:0]       ex_rd,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             proto_err
);

    typedef enum logic {
        StRun     = 1'b0,
        StMulBusy = 1'b1
    } state_e;

    localparam logic [3:0] McntInit = 4'(MUL_LAT - 1);

    state_e           state_q, state_d;
    logic [3:0]       mcnt_q, mcnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             proto_err_q, proto_err_d;

    logic lu;
    logic stall_inc;
    logic flush_inc;

    // r0 is hardwired zero, so a load targeting it never creates a hazard.
    always_comb begin
        lu = id_valid && ex_valid && ex_memread && ex_regwrite && (ex_rd != 3'd0) &&
             ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    end

    always_comb begin
        state_d      = state_q;
        mcnt_d       = mcnt_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        proto_err_d  = proto_err_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;

        if (!rst_n) begin
            // Drain the pipeline to NOPs while reset is held.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
        end else if (state_q == StMulBusy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            stall_inc   = 1'b1;
            // A branch cannot resolve while EX holds a multiply; flag the source.
            if (branch_taken) begin
                proto_err_d = 1'b1;
            end
            mcnt_d = mcnt_q - 4'd1;
            if (mcnt_q == 4'd1) begin
                state_d = StRun;
            end
        end else if (branch_taken) begin
            // Squash IF/ID and ID/EX; a coincident lu or mul issue is wrong-path.
            pc_write     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
        end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
        end else if (id_valid && id_is_mul) begin
            // The multiply enters ID/EX on this edge and then holds EX.
            state_d = StMulBusy;
            mcnt_d  = McntInit;
        end
    end

    // Counters saturate at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_inc && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if (flush_inc && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StRun;
            mcnt_q        <= 4'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mcnt_q        <= mcnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign mul_busy    = (state_q == StMulBusy);
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned CNT_W   = 8;

    logic             clk;
    logic             rst_n;
    logic             mem_stall;
    logic             branch_taken;
    logic             id_valid;
    logic [2:0]       id_rs;
    logic [2:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_mul;
    logic             ex_valid;
    logic             ex_memread;
    logic             ex_regwrite;
    logic [2:0]       ex_rd;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_bubble;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             proto_err;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stall = 0;
    int busy_cycles;

    hazard_controller #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_stall    (mem_stall),
        .branch_taken (branch_taken),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_is_mul    (id_is_mul),
        .ex_valid     (ex_valid),
        .ex_memread   (ex_memread),
        .ex_regwrite  (ex_regwrite),
        .ex_rd        (ex_rd),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_write  (id_ex_write),
        .id_ex_bubble (id_ex_bubble),
        .mul_busy     (mul_busy),
        .stall_count  (stall_count),
        .flush_count  (flush_count),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change 1 ns after it, outputs are checked 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_stall    = 1'b0;
        branch_taken = 1'b0;
        id_valid     = 1'b0;
        id_rs        = 3'd0;
        id_rt        = 3'd0;
        id_uses_rs   = 1'b0;
        id_uses_rt   = 1'b0;
        id_is_mul    = 1'b0;
        ex_valid     = 1'b0;
        ex_memread   = 1'b0;
        ex_regwrite  = 1'b0;
        ex_rd        = 3'd0;
    endtask

    // Load in EX writing r3, ID instruction reads r3 through rs.
    task automatic set_load_use();
        id_valid    = 1'b1;
        ex_valid    = 1'b1;
        ex_memread  = 1'b1;
        ex_regwrite = 1'b1;
        ex_rd       = 3'd3;
        id_rs       = 3'd3;
        id_uses_rs  = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        // Reset-held outputs
        check_eq("rst_pc_write", {31'd0, pc_write}, 32'd0);
        check_eq("rst_if_id_write", {31'd0, if_id_write}, 32'd0);
        check_eq("rst_if_id_flush", {31'd0, if_id_flush}, 32'd1);
        check_eq("rst_id_ex_write", {31'd0, id_ex_write}, 32'd1);
        check_eq("rst_id_ex_bubble", {31'd0, id_ex_bubble}, 32'd1);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("init_stall_cnt", 32'(stall_count), 32'd0);
        check_eq("init_flush_cnt", 32'(flush_count), 32'd0);
        check_eq("init_mul_busy", {31'd0, mul_busy}, 32'd0);
        check_eq("init_proto_err", {31'd0, proto_err}, 32'd0);
        check_eq("idle_enables", {28'd0, pc_write, if_id_write, id_ex_write, if_id_flush},
                 32'b1110);

        // Load-use through rs
        set_load_use();
        #1;
        check_eq("lu_pc_write", {31'd0, pc_write}, 32'd0);
        check_eq("lu_if_id_write", {31'd0, if_id_write}, 32'd0);
        check_eq("lu_id_ex_bubble", {31'd0, id_ex_bubble}, 32'd1);
        check_eq("lu_id_ex_write", {31'd0, id_ex_write}, 32'd1);
        step();
        exp_stall++;
        clear_inputs();
        #1;
        check_eq("lu_one_cycle", {31'd0, pc_write}, 32'd1);
        check_eq("lu_stall_cnt", 32'(stall_count), 32'(exp_stall));

        // Same stimulus targeting r0: no hazard
        set_load_use();
        ex_rd = 3'd0;
        id_rs = 3'd0;
        #1;
        check_eq("r0_pc_write", {31'd0, pc_write}, 32'd1);
        check_eq("r0_bubble", {31'd0, id_ex_bubble}, 32'd0);
        step();
        clear_inputs();
        #1;
        check_eq("r0_stall_cnt", 32'(stall_count), 32'(exp_stall));

        // Load-use through rt, then rt match without uses_rt
        set_load_use();
        id_uses_rs = 1'b0;
        id_rs      = 3'd1;
        id_rt      = 3'd5;
        ex_rd      = 3'd5;
        id_uses_rt = 1'b1;
        #1;
        check_eq("rt_lu_pc_write", {31'd0, pc_write}, 32'd0);
        id_uses_rt = 1'b0;
        #1;
        check_eq("rt_unused_pc_write", {31'd0, pc_write}, 32'd1);
        id_uses_rt = 1'b1;
        step();
        exp_stall++;
        clear_inputs();
        #1;
        check_eq("rt_stall_cnt", 32'(stall_count), 32'(exp_stall));

        // Multiply issue at t: busy t+1..t+3, RUN at t+4
        id_valid  = 1'b1;
        id_is_mul = 1'b1;
        #1;
        check_eq("mul_issue_busy", {31'd0, mul_busy}, 32'd0);
        check_eq("mul_issue_idex", {31'd0, id_ex_write}, 32'd1);
        step();
        clear_inputs();
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            #1;
            check_eq($sformatf("mul_busy_t%0d", i), {31'd0, mul_busy}, 32'd1);
            check_eq($sformatf("mul_idex_t%0d", i), {30'd0, id_ex_write, pc_write}, 32'd0);
            step();
            exp_stall++;
        end
        #1;
        check_eq("mul_done_busy", {31'd0, mul_busy}, 32'd0);
        check_eq("mul_done_idex", {31'd0, id_ex_write}, 32'd1);
        check_eq("mul_stall_cnt", 32'(stall_count), 32'(exp_stall));

        // Branch with coincident load-use and multiply: branch wins
        set_load_use();
        id_is_mul    = 1'b1;
        branch_taken = 1'b1;
        #1;
        check_eq("br_ctrl", {28'd0, if_id_flush, id_ex_bubble, pc_write, id_ex_write},
                 32'b1111);
        step();
        clear_inputs();
        #1;
        check_eq("br_flush_cnt", 32'(flush_count), 32'd1);
        check_eq("br_stall_cnt", 32'(stall_count), 32'(exp_stall));
        check_eq("br_no_mul", {31'd0, mul_busy}, 32'd0);

        // Freeze mid-multiply at mcnt=2 for 3 cycles
        id_valid  = 1'b1;
        id_is_mul = 1'b1;
        #1;
        step();
        clear_inputs();
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            mem_stall = (i >= 1 && i <= 3);
            #1;
            if (!mul_busy) break;
            busy_cycles++;
            if (i == 2) begin
                check_eq("frz_enables",
                         {27'd0, pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble},
                         32'd0);
            end
            if (i == 4) begin
                check_eq("frz_mcnt_held", 32'(dut.mcnt_q), 32'd2);
            end
            step();
            if (!mem_stall) exp_stall++;
        end
        mem_stall = 1'b0;
        check_eq("frz_busy_cycles", 32'(busy_cycles), 32'(MUL_LAT - 1 + 3));
        check_eq("frz_stall_cnt", 32'(stall_count), 32'(exp_stall));

        // Branch during MUL_BUSY sets proto_err, no flush
        id_valid  = 1'b1;
        id_is_mul = 1'b1;
        #1;
        step();
        clear_inputs();
        branch_taken = 1'b1;
        #1;
        check_eq("perr_no_flush", {30'd0, if_id_flush, pc_write}, 32'd0);
        step();
        exp_stall++;
        branch_taken = 1'b0;
        #1;
        check_eq("perr_set", {31'd0, proto_err}, 32'd1);
        check_eq("perr_flush_cnt", 32'(flush_count), 32'd1);
        check_eq("perr_stall_cnt", 32'(stall_count), 32'(exp_stall));

        // Reset mid-MUL_BUSY
        rst_n = 1'b0;
        #1;
        check_eq("mrst_flush_bubble", {30'd0, if_id_flush, id_ex_bubble}, 32'b11);
        check_eq("mrst_pc_write", {31'd0, pc_write}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("mrst_busy", {31'd0, mul_busy}, 32'd0);
        check_eq("mrst_perr", {31'd0, proto_err}, 32'd0);
        check_eq("mrst_counts", {16'd0, 8'(stall_count), 8'(flush_count)}, 32'd0);
        check_eq("mrst_mcnt", 32'(dut.mcnt_q), 32'd0);

        // Saturation: 2^CNT_W+5 load-use stalls
        set_load_use();
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            step();
            if (i == (1 << CNT_W) - 3) begin
                check_eq("sat_pre", 32'(stall_count), 32'((1 << CNT_W) - 2));
            end
        end
        clear_inputs();
        #1;
        check_eq("sat_all_ones", 32'(stall_count), 32'((1 << CNT_W) - 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
